mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/tinyml_mem_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinyml_mem_pkg.sv
// Shared defaults and types for the memory arbiter.
// Holds bus width defaults, the requester-id type and the arbiter state enum.
package tinyml_mem_pkg;

  localparam int MEM_NUM_REQ = 4;
  localparam int MEM_ADDR_W  = 24;
  localparam int MEM_DATA_W  = 8;

  typedef logic [$clog2(MEM_NUM_REQ)-1:0] req_id_t;

  typedef enum logic {
    ARB = 1'b0,
    OWN = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: searches req starting at (last+1) mod NUM_REQ.
// Ports: req (vector), last (previous owner) -> found, winner (index).
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last,
  output logic                       found,
  output logic [$clog2(NUM_REQ)-1:0] winner
);

  localparam int IW = $clog2(NUM_REQ);

  // Walk from the farthest slot to the nearest so the nearest
  // requester after 'last' is the one left in winner.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[(int'(last) + k) % NUM_REQ]) begin
        found  = 1'b1;
        winner = IW'((int'(last) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin read arbiter: one owner at a time streams reads to a
// synchronous memory; responses return one cycle later, tagged.
// Ports: clk, rst_n, req/req_addr in; gnt, rsp_valid, rsp_rdata out;
// mem_en/mem_addr out, mem_rdata in; owner_id, busy status.
// Optional: MEM_ARBITER_MAX_BURST_EN caps beats per ownership.
module mem_arbiter
  import tinyml_mem_pkg::*;
#(
  parameter int NUM_REQ    = MEM_NUM_REQ,
  parameter int ADDR_WIDTH = MEM_ADDR_W,
  parameter int DATA_WIDTH = MEM_DATA_W,
  parameter int MAX_BURST  = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          mem_en,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  input  logic [DATA_WIDTH-1:0]         mem_rdata,
  output logic [$clog2(NUM_REQ)-1:0]    owner_id,
  output logic                          busy
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] tag_q;
  logic          pend_q;
  logic          found;
  logic [IW-1:0] winner;
  logic          issue;
  logic          burst_last;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .req   (req),
    .last  (last_q),
    .found (found),
    .winner(winner)
  );

`ifdef MEM_ARBITER_MAX_BURST_EN
  localparam int BW = $clog2(MAX_BURST + 1);
  logic [BW-1:0] burst_q;

  assign burst_last = (burst_q == BW'(MAX_BURST - 1));

  // Cleared while arbitrating, so every ownership starts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_q <= '0;
    end else if (state_q == ARB) begin
      burst_q <= '0;
    end else if (issue) begin
      burst_q <= burst_q + 1'b1;
    end
  end
`else
  logic unused_max;
  assign unused_max = (MAX_BURST > 0);
  assign burst_last = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    issue   = 1'b0;
    unique case (state_q)
      ARB: begin
        if (found) begin
          state_d = OWN;
          owner_d = winner;
        end
      end
      OWN: begin
        issue = req[owner_q];
        // Release on req drop, or after the last beat of a capped burst.
        if (!issue || burst_last) begin
          state_d = ARB;
          last_d  = owner_q;
          owner_d = '0;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB;
      owner_q <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      pend_q  <= 1'b0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      pend_q  <= issue;
      if (issue) begin
        tag_q <= owner_q;
      end
    end
  end

  always_comb begin
    gnt       = '0;
    rsp_valid = '0;
    rsp_rdata = '0;
    mem_addr  = '0;
    if (issue) begin
      gnt[owner_q] = 1'b1;
      mem_addr = req_addr[owner_q*ADDR_WIDTH +: ADDR_WIDTH];
    end
    if (pend_q) begin
      rsp_valid[tag_q] = 1'b1;
      rsp_rdata = mem_rdata;
    end
  end

  assign mem_en   = issue;
  assign owner_id = owner_q;
  assign busy     = (state_q == OWN) || pend_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed
// sequences and random traffic against a behavioural model.
module tb_mem_arbiter;

  localparam int N    = 4;
  localparam int AW   = 24;
  localparam int DW   = 8;
  localparam int MAXB = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            mem_en;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_rdata = '0;
  logic [1:0]      owner_id;
  logic            busy;

  mem_arbiter #(
    .NUM_REQ   (N),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MAX_BURST (MAXB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_addr (req_addr),
    .gnt      (gnt),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .mem_en   (mem_en),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .owner_id (owner_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
  endfunction

  // Synchronous memory: data one cycle after the enable.
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= mem_byte(mem_addr);
  end

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    else
      passed++;
  endtask

  // Behavioural model: m_own = -1 means nobody owns the bus.
  int          m_own;
  int          m_last;
  int          m_pend;
  int          m_cnt;
  logic [23:0] m_paddr;

  task automatic model_reset();
    m_own   = -1;
    m_last  = N - 1;
    m_pend  = -1;
    m_cnt   = 0;
    m_paddr = '0;
  endtask

  logic [N-1:0] act_gnt, act_rsp;
  logic [7:0]   act_rdata;
  logic [1:0]   act_own;
  logic         act_busy, act_en;

  // One clock cycle: drive, sample mid-cycle, compare, advance.
  task automatic cyc(input logic [N-1:0] r,
                     input logic [N*AW-1:0] a);
    logic [N-1:0] e_gnt, e_rsp;
    logic [7:0]   e_rd;
    logic [23:0]  e_addr;
    logic [1:0]   e_own;
    logic         e_busy, iss, hit;
    req = r;
    req_addr = a;
    #4;
    act_gnt = gnt;
    act_rsp = rsp_valid;
    act_rdata = rsp_rdata;
    act_own = owner_id;
    act_busy = busy;
    act_en = mem_en;
    iss = (m_own >= 0) && r[m_own];
    e_gnt = iss ? 4'(1 << m_own) : 4'd0;
    e_addr = iss ? a[m_own*AW +: AW] : 24'd0;
    e_rsp = (m_pend >= 0) ? 4'(1 << m_pend) : 4'd0;
    e_rd = (m_pend >= 0) ? mem_byte(m_paddr) : 8'd0;
    e_own = (m_own >= 0) ? 2'(m_own) : 2'd0;
    e_busy = (m_own >= 0) || (m_pend >= 0);
    chk("gnt", 64'(gnt), 64'(e_gnt));
    chk("mem_en", 64'(mem_en), 64'(iss));
    chk("mem_addr", 64'(mem_addr), 64'(e_addr));
    chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(e_rd));
    chk("owner_id", 64'(owner_id), 64'(e_own));
    chk("busy", 64'(busy), 64'(e_busy));
    chk("gnt_1hot", 64'($onehot0(gnt)), 64'd1);
    chk("rsp_1hot", 64'($onehot0(rsp_valid)), 64'd1);
    chk("en_or_gnt", 64'(mem_en), 64'(|gnt));
    m_pend = iss ? m_own : -1;
    if (iss) m_paddr = e_addr;
    if (m_own < 0) begin
      hit = 1'b0;
      for (int k = 1; k <= N; k++) begin
        if (!hit && r[(m_last + k) % N]) begin
          hit = 1'b1;
          m_own = (m_last + k) % N;
          m_cnt = 0;
        end
      end
    end else if (!iss) begin
      m_last = m_own;
      m_own = -1;
    end else begin
      m_cnt++;
`ifdef MEM_ARBITER_MAX_BURST_EN
      if (m_cnt == MAXB) begin
        m_last = m_own;
        m_own = -1;
      end
`endif
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset applied away from the edge; outputs must clear.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_rsp", 64'(rsp_valid), 64'd0);
    chk("rst_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_en", 64'(mem_en), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_own", 64'(owner_id), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [3:0] rsp;
    logic [1:0] own;
    logic       busy;
  } vec_t;

  vec_t tbl[16];

  logic [N*AW-1:0] addrs;
  logic [N-1:0]    rq;
  int n, k, first, lastg, c;

  initial begin
    tbl[0]  = '{4'b1111, 4'h0, 4'h0, 2'd0, 1'b0};
    tbl[1]  = '{4'b1111, 4'h1, 4'h0, 2'd0, 1'b1};
    tbl[2]  = '{4'b1110, 4'h0, 4'h1, 2'd0, 1'b1};
    tbl[3]  = '{4'b1110, 4'h0, 4'h0, 2'd0, 1'b0};
    tbl[4]  = '{4'b1110, 4'h2, 4'h0, 2'd1, 1'b1};
    tbl[5]  = '{4'b1100, 4'h0, 4'h2, 2'd1, 1'b1};
    tbl[6]  = '{4'b1100, 4'h0, 4'h0, 2'd0, 1'b0};
    tbl[7]  = '{4'b1100, 4'h4, 4'h0, 2'd2, 1'b1};
    tbl[8]  = '{4'b1000, 4'h0, 4'h4, 2'd2, 1'b1};
    tbl[9]  = '{4'b1001, 4'h0, 4'h0, 2'd0, 1'b0};
    tbl[10] = '{4'b1001, 4'h8, 4'h0, 2'd3, 1'b1};
    tbl[11] = '{4'b0001, 4'h0, 4'h8, 2'd3, 1'b1};
    tbl[12] = '{4'b0001, 4'h0, 4'h0, 2'd0, 1'b0};
    tbl[13] = '{4'b0001, 4'h1, 4'h0, 2'd0, 1'b1};
    tbl[14] = '{4'b0000, 4'h0, 4'h1, 2'd0, 1'b1};
    tbl[15] = '{4'b0000, 4'h0, 4'h0, 2'd0, 1'b0};

    rst_n = 1'b0;
    req = '0;
    req_addr = '0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Rotation 0,1,2,3,0 from reset.
    addrs = {24'h300033, 24'h200022, 24'h100011, 24'h000000};
    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].req, addrs);
      chk($sformatf("t%0d_gnt", i), 64'(act_gnt), 64'(tbl[i].gnt));
      chk($sformatf("t%0d_rsp", i), 64'(act_rsp), 64'(tbl[i].rsp));
      chk($sformatf("t%0d_own", i), 64'(act_own), 64'(tbl[i].own));
      chk($sformatf("t%0d_busy", i), 64'(act_busy), 64'(tbl[i].busy));
      chk($sformatf("t%0d_en", i), 64'(act_en), 64'(|tbl[i].gnt));
    end

    // Single requester streaming 32 beats.
    do_reset();
    n = 0; k = 0; first = -1; lastg = -1;
    for (c = 0; c < 70 && k < 32; c++) begin
      addrs = '0;
      addrs[2*AW +: AW] = 24'h000100 + 24'(n);
      rq = (n < 32) ? 4'b0100 : 4'b0000;
      cyc(rq, addrs);
      if (act_rsp[2]) begin
        chk("burst_rdata", 64'(act_rdata),
            64'(mem_byte(24'h000100 + 24'(k))));
        k++;
      end
      if (act_gnt[2]) begin
        if (first < 0) first = c;
        lastg = c;
        n++;
      end
    end
    chk("burst_gnts", 64'(n), 64'd32);
    chk("burst_rsps", 64'(k), 64'd32);
    chk("burst_first", 64'(first), 64'd1);
`ifndef MEM_ARBITER_MAX_BURST_EN
    chk("burst_last", 64'(lastg), 64'd32);
`endif

    // Owner 1 releases while requester 3 rises.
    do_reset();
    addrs = {24'h0000AA, 24'h000000, 24'h000055, 24'h000000};
    cyc(4'b0010, addrs);
    cyc(4'b0010, addrs);
    chk("rel_gnt1a", 64'(act_gnt), 64'h2);
    cyc(4'b0010, addrs);
    chk("rel_gnt1b", 64'(act_gnt), 64'h2);
    cyc(4'b1000, addrs);
    chk("rel_rsp1", 64'(act_rsp), 64'h2);
    chk("rel_nogntA", 64'(act_gnt), 64'h0);
    cyc(4'b1000, addrs);
    chk("rel_nogntB", 64'(act_gnt), 64'h0);
    cyc(4'b1000, addrs);
    chk("rel_gnt3", 64'(act_gnt), 64'h8);
    repeat (3) cyc(4'b0000, addrs);

    // Requesters 0 and 1 held high.
    do_reset();
    addrs = {24'h0, 24'h0, 24'h000707, 24'h000303};
    for (int i = 0; i < 22; i++) begin
      logic [3:0] eg;
      cyc(4'b0011, addrs);
      eg = 4'h0;
      if (i >= 1) begin
`ifdef MEM_ARBITER_MAX_BURST_EN
        if ((i - 1) % 5 != 4)
          eg = 4'(1 << (((i - 1) / 5) % 2));
`else
        eg = 4'h1;
`endif
      end
      chk($sformatf("hold_gnt%0d", i), 64'(act_gnt), 64'(eg));
    end
    repeat (3) cyc(4'b0000, addrs);

    // Reset one cycle after a grant drops the pending response.
    do_reset();
    addrs = {24'h0, 24'h012345, 24'h0, 24'h0};
    cyc(4'b0100, addrs);
    cyc(4'b0100, addrs);
    chk("rm_gnt2", 64'(act_gnt), 64'h4);
    do_reset();
    cyc(4'b1111, addrs);
    chk("rm_norsp", 64'(act_rsp), 64'h0);
    cyc(4'b1111, addrs);
    chk("rm_first0", 64'(act_gnt), 64'h1);
    repeat (2) cyc(4'b0000, addrs);

    // Random traffic against the model.
    do_reset();
    rq = '0;
    for (int i = 0; i < N; i++)
      addrs[i*AW +: AW] = 24'($urandom);
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(3) == 0) rq[i] = ~rq[i];
      cyc(rq, addrs);
      for (int i = 0; i < N; i++)
        if (act_gnt[i] || !rq[i])
          addrs[i*AW +: AW] = 24'($urandom);
    end
    repeat (3) cyc(4'b0000, addrs);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
